// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mac_pkg
//  Brief   : Shared constants, result type and saturating-add helper for the
//            pipelined multiply-accumulate block.
//  Rev     : 1.0  initial release
// ============================================================================

`ifndef MAC_PKG_SV
`define MAC_PKG_SV

// Elaboration-time guard: the accumulator must hold a full product, and the
// helper arithmetic below works in a 64-bit container.
`define MAC_CHECK_WIDTHS(DW, AW) \
    if (((AW) < 2 * (DW)) || ((AW) > 62)) begin : g_width_check \
        $error("mac_pipe_acc: ACC_W must satisfy 2*DATA_W <= ACC_W <= 62"); \
    end

package mac_pkg;

    localparam int MAC_MAX_W = 64;

    typedef struct packed {
        logic                        ovf;
        logic signed [MAC_MAX_W-1:0] sum;
    } sat_res_t;

    // Largest value representable in an accw-bit signed accumulator.
    function automatic logic signed [MAC_MAX_W-1:0] acc_max(input int accw);
        return (64'sd1 <<< (accw - 1)) - 64'sd1;
    endfunction

    // Smallest value representable in an accw-bit signed accumulator.
    function automatic logic signed [MAC_MAX_W-1:0] acc_min(input int accw);
        return -(64'sd1 <<< (accw - 1));
    endfunction

    // Adds two accw-bit values held sign-extended in 64 bits. The wide sum
    // cannot itself overflow, so the range test is exact. With saturate set
    // the result is clamped; otherwise the caller keeps the low accw bits.
    function automatic sat_res_t sat_add(input logic signed [MAC_MAX_W-1:0] a,
                                         input logic signed [MAC_MAX_W-1:0] b,
                                         input int                          accw,
                                         input logic                        saturate);
        sat_res_t                    r;
        logic signed [MAC_MAX_W-1:0] s;
        s     = a + b;
        r.ovf = (s > acc_max(accw)) || (s < acc_min(accw));
        r.sum = s;
        if (r.ovf && saturate) begin
            r.sum = s[MAC_MAX_W-1] ? acc_min(accw) : acc_max(accw);
        end
        return r;
    endfunction

endpackage

`endif

`default_nettype wire

// File: rtl/mac_mul_stage.sv
`default_nettype none
// ============================================================================
//  Module  : mac_mul_stage
//  Brief   : Operand register (S1) followed by signed multiply register (S2);
//            valid and clear bits travel alongside the data.
//  Rev     : 1.0  initial release
// ============================================================================
module mac_mul_stage
    import mac_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       i_valid,
    input  logic                       i_clear,
    input  logic signed [DATA_W-1:0]   i_x,
    input  logic signed [DATA_W-1:0]   i_y,
    output logic signed [2*DATA_W-1:0] o_p,
    output logic                       o_valid,
    output logic                       o_clear
);

    logic signed [DATA_W-1:0]   r_s1_x;
    logic signed [DATA_W-1:0]   r_s1_y;
    logic                       r_s1_valid;
    logic                       r_s1_clear;
    logic signed [2*DATA_W-1:0] r_s2_p;
    logic                       r_s2_valid;
    logic                       r_s2_clear;
    logic signed [2*DATA_W-1:0] w_prod;

    // Operands are sign-extended before multiplying so the full product fits.
    assign w_prod = (2*DATA_W)'(r_s1_x) * (2*DATA_W)'(r_s1_y);

    // S1 captures the inputs, S2 captures the product; reset drops in-flight work.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s1_x     <= '0;
            r_s1_y     <= '0;
            r_s1_valid <= 1'b0;
            r_s1_clear <= 1'b0;
            r_s2_p     <= '0;
            r_s2_valid <= 1'b0;
            r_s2_clear <= 1'b0;
        end else begin
            r_s1_x     <= i_x;
            r_s1_y     <= i_y;
            r_s1_valid <= i_valid;
            r_s1_clear <= i_clear;
            r_s2_p     <= w_prod;
            r_s2_valid <= r_s1_valid;
            r_s2_clear <= r_s1_clear;
        end
    end

    assign o_p     = r_s2_p;
    assign o_valid = r_s2_valid;
    assign o_clear = r_s2_clear;

endmodule
`default_nettype wire

// File: rtl/mac_pipe_acc.sv
`default_nettype none
// ============================================================================
//  Module  : mac_pipe_acc
//  Brief   : 3-stage pipelined signed multiply-accumulate with optional
//            dot-product framing, saturating or wrapping accumulation and a
//            sticky overflow flag.
//  Rev     : 1.0  initial release
// ============================================================================
module mac_pipe_acc
    import mac_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 19,
    parameter int VEC_LEN  = 0,
    parameter int SATURATE = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] y,
    input  logic                     macc_clear,
    output logic signed [ACC_W-1:0]  acc_out,
    output logic                     acc_valid,
    output logic                     overflow
);

    `MAC_CHECK_WIDTHS(DATA_W, ACC_W)

    localparam int                 C_CNT_W  = (VEC_LEN > 0) ? $clog2(VEC_LEN + 1) : 1;
    localparam bit                 C_FRAMED = (VEC_LEN > 0);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(VEC_LEN);

    logic signed [2*DATA_W-1:0] w_p;
    logic                       w_p_valid;
    logic                       w_p_clear;
    logic signed [ACC_W-1:0]    w_sp;
    sat_res_t                   w_add;
    logic                       w_unused_sum_hi;

    logic signed [ACC_W-1:0]    r_acc;
    logic [C_CNT_W-1:0]         r_cnt;
    logic                       r_ovf;
    logic                       r_vld;

    logic signed [ACC_W-1:0]    w_acc_nxt;
    logic [C_CNT_W-1:0]         w_cnt_nxt;
    logic                       w_ovf_nxt;
    logic                       w_vld_nxt;

    mac_mul_stage #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .i_valid (in_valid),
        .i_clear (macc_clear),
        .i_x     (x),
        .i_y     (y),
        .o_p     (w_p),
        .o_valid (w_p_valid),
        .o_clear (w_p_clear)
    );

    assign w_sp  = ACC_W'(w_p);
    assign w_add = sat_add(64'(r_acc), 64'(w_sp), ACC_W, (SATURATE != 0));
    // Bits above ACC_W are only a by-product of the 64-bit helper.
    assign w_unused_sum_hi = ^w_add.sum[MAC_MAX_W-1:ACC_W];

    // S3 next state: clear beats load beats accumulate; completing a frame
    // pulses acc_valid and rewinds the count so the next sample loads.
    always_comb begin
        w_acc_nxt = r_acc;
        w_cnt_nxt = r_cnt;
        w_ovf_nxt = r_ovf;
        w_vld_nxt = 1'b0;
        if (w_p_clear && !w_p_valid) begin
            w_acc_nxt = '0;
            w_cnt_nxt = '0;
            w_ovf_nxt = 1'b0;
        end else if (w_p_clear) begin
            w_acc_nxt = w_sp;
            w_cnt_nxt = C_CNT_W'(1);
            w_ovf_nxt = 1'b0;
        end else if (w_p_valid && C_FRAMED && (r_cnt == '0)) begin
            w_acc_nxt = w_sp;
            w_cnt_nxt = C_CNT_W'(1);
        end else if (w_p_valid) begin
            w_acc_nxt = w_add.sum[ACC_W-1:0];
            w_cnt_nxt = r_cnt + C_CNT_W'(1);
            w_ovf_nxt = r_ovf | w_add.ovf;
        end
        if (C_FRAMED && w_p_valid && (w_cnt_nxt == C_CNT_LAST)) begin
            w_vld_nxt = 1'b1;
            w_cnt_nxt = '0;
        end
        if (!C_FRAMED) begin
            w_cnt_nxt = '0;
        end
    end

    // Accumulator, frame counter and flag registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_vld <= 1'b0;
        end else begin
            r_acc <= w_acc_nxt;
            r_cnt <= w_cnt_nxt;
            r_ovf <= w_ovf_nxt;
            r_vld <= w_vld_nxt;
        end
    end

    assign acc_out   = r_acc;
    assign acc_valid = r_vld;
    assign overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mac_pipe_acc.sv
`default_nettype none
// ============================================================================
//  Module  : tb_mac_pipe_acc
//  Brief   : Self-checking bench. Four configurations (legacy, framed,
//            16-bit saturating, 16-bit wrapping) share one stimulus stream and
//            are each compared every cycle with an arithmetic reference model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_mac_pipe_acc;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              macc_clear = 1'b0;
    logic signed [7:0] x = '0;
    logic signed [7:0] y = '0;

    logic signed [18:0] acc0;
    logic signed [18:0] acc1;
    logic signed [15:0] acc2;
    logic signed [15:0] acc3;
    logic [3:0]         vld;
    logic [3:0]         ovf;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mac_pipe_acc #(.DATA_W(8), .ACC_W(19), .VEC_LEN(0), .SATURATE(0)) u_dut_legacy (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .x(x), .y(y),
        .macc_clear(macc_clear), .acc_out(acc0), .acc_valid(vld[0]), .overflow(ovf[0]));
    mac_pipe_acc #(.DATA_W(8), .ACC_W(19), .VEC_LEN(4), .SATURATE(0)) u_dut_frame (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .x(x), .y(y),
        .macc_clear(macc_clear), .acc_out(acc1), .acc_valid(vld[1]), .overflow(ovf[1]));
    mac_pipe_acc #(.DATA_W(8), .ACC_W(16), .VEC_LEN(0), .SATURATE(1)) u_dut_sat (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .x(x), .y(y),
        .macc_clear(macc_clear), .acc_out(acc2), .acc_valid(vld[2]), .overflow(ovf[2]));
    mac_pipe_acc #(.DATA_W(8), .ACC_W(16), .VEC_LEN(0), .SATURATE(0)) u_dut_wrap (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .x(x), .y(y),
        .macc_clear(macc_clear), .acc_out(acc3), .acc_valid(vld[3]), .overflow(ovf[3]));

    // Reference model configuration, one entry per instance above.
    int cfg_accw [4] = '{19, 19, 16, 16};
    int cfg_vlen [4] = '{0, 4, 0, 0};
    bit cfg_sat  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    typedef struct {
        bit     v;
        bit     c;
        longint xv;
        longint yv;
    } smp_t;

    longint m_acc [4];
    int     m_cnt [4];
    bit     m_ovf [4];
    bit     m_vld [4];
    smp_t   m_s1;
    smp_t   m_s2;
    smp_t   bubble = '{1'b0, 1'b0, 0, 0};

    function automatic longint get_acc(input int k);
        case (k)
            0:       return longint'(acc0);
            1:       return longint'(acc1);
            2:       return longint'(acc2);
            default: return longint'(acc3);
        endcase
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_acc[k] = 0;
            m_cnt[k] = 0;
            m_ovf[k] = 1'b0;
            m_vld[k] = 1'b0;
        end
        m_s1 = bubble;
        m_s2 = bubble;
    endtask

    // Applies one product-stage record to configuration k using plain
    // integer arithmetic on the mathematical sum.
    task automatic model_apply(input int k, input smp_t r);
        longint p, s, lo, hi, md;
        int     w;
        w  = cfg_accw[k];
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -(longint'(1) <<< (w - 1));
        md = longint'(1) <<< w;
        p  = r.xv * r.yv;
        m_vld[k] = 1'b0;
        if (r.c && !r.v) begin
            m_acc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 1'b0;
        end else if (r.c) begin
            m_acc[k] = p; m_cnt[k] = 1; m_ovf[k] = 1'b0;
        end else if (r.v) begin
            if (cfg_vlen[k] > 0 && m_cnt[k] == 0) begin
                m_acc[k] = p;
                m_cnt[k] = 1;
            end else begin
                s = m_acc[k] + p;
                if (s > hi || s < lo) begin
                    m_ovf[k] = 1'b1;
                    if (cfg_sat[k]) s = (s > hi) ? hi : lo;
                    else begin
                        s = (s - lo) % md;
                        if (s < 0) s = s + md;
                        s = s + lo;
                    end
                end
                m_acc[k] = s;
                m_cnt[k] = m_cnt[k] + 1;
            end
        end
        if (cfg_vlen[k] > 0 && r.v && m_cnt[k] == cfg_vlen[k]) begin
            m_vld[k] = 1'b1;
            m_cnt[k] = 0;
        end
    endtask

    // One clock: drive inputs, advance the model across the edge, then
    // compare every instance on the falling edge.
    task automatic step(input bit rn, input bit v, input bit c, input int xv, input int yv);
        smp_t cur;
        reset_n    = rn;
        in_valid   = v;
        macc_clear = c;
        x          = xv[7:0];
        y          = yv[7:0];
        cur = '{v, c, longint'(xv), longint'(yv)};
        @(posedge clk);
        if (!rn) begin
            model_reset();
        end else begin
            for (int k = 0; k < 4; k++) model_apply(k, m_s2);
            m_s2 = m_s1;
            m_s1 = cur;
        end
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("c%0d_acc", k), get_acc(k), m_acc[k]);
            chk($sformatf("c%0d_valid", k), longint'(vld[k]), longint'(m_vld[k]));
            chk($sformatf("c%0d_ovf", k), longint'(ovf[k]), longint'(m_ovf[k]));
        end
    endtask

    longint wrap_exp [5] = '{16384, -32768, -16384, 0, 16384};

    initial begin
        model_reset();

        // Reset state.
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("reset_acc0", longint'(acc0), 0);

        // Legacy: clear+valid x=-1,y=2 then 9 more; result 3 edges after sample.
        for (int i = 0; i < 12; i++) begin
            if (i < 10) step(1, 1, (i == 0), -1, 2);
            else        step(1, 0, 0, 0, 0);
            if (i >= 2) chk("legacy_seq", longint'(acc0), -2 * longint'(i - 1));
        end

        // Framing: clear, then x=3,y=5 continuous.
        step(1, 0, 1, 0, 0);
        for (int i = 0; i < 12; i++) begin
            step(1, 1, 0, 3, 5);
            if (i >= 2) begin
                chk("frame_acc", longint'(acc1), 15 * longint'(((i - 2) % 4) + 1));
                chk("frame_valid", longint'(vld[1]), longint'(((i - 2) % 4) == 3));
            end
        end

        // Saturating vs wrapping: clear, then x=y=-128 continuous.
        step(1, 0, 1, 0, 0);
        for (int i = 0; i < 7; i++) begin
            step(1, 1, 0, -128, -128);
            if (i >= 2) begin
                chk("sat_acc", longint'(acc2), (i == 2) ? 16384 : 32767);
                chk("wrap_acc", longint'(acc3), wrap_exp[i - 2]);
                chk("sat_ovf", longint'(ovf[2]), longint'(i > 2));
            end
        end

        // Mid-stream clear+valid after reaching 40, then clear without valid.
        step(1, 0, 1, 0, 0);
        step(1, 1, 0, 5, 8);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("mid_40", longint'(acc0), 40);
        step(1, 1, 1, 2, 3);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("mid_6", longint'(acc0), 6);
        chk("mid_ovf", longint'(ovf[2]), 0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("mid_zero", longint'(acc0), 0);

        // Bubbles: valid 1,0,0,1.
        step(1, 1, 0, 1, 7);
        step(1, 0, 0, 9, 9);
        step(1, 0, 0, 9, 9);
        step(1, 1, 0, 1, 7);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("bubble_acc", longint'(acc0), 14);

        // Reset with three samples in flight; nothing stale afterwards.
        step(1, 1, 0, 11, 11);
        step(1, 1, 0, 12, 12);
        step(1, 1, 0, 13, 13);
        step(0, 0, 0, 0, 0);
        chk("rst_acc", longint'(acc0), 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
        chk("rst_stale", longint'(acc0), 0);

        // Randomised traffic with occasional clears and resets.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(99) != 0),
                 ($urandom_range(3) != 0),
                 ($urandom_range(19) == 0),
                 int'($urandom_range(255)) - 128,
                 int'($urandom_range(255)) - 128);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
